// File: rtl/fpalu_pkg.sv
// Shared FP sequencer definitions: opcode encodings, FSM states, flag layout.
// Pure declarations; no timing or flow control of its own.
package fpalu_pkg;

  localparam int FOPNULL   = 0;
  localparam int FOPADD    = 1;
  localparam int FOPSUB    = 2;
  localparam int FOPMUL    = 3;
  localparam int FOPDIV    = 4;
  localparam int FOPSQRT   = 5;
  localparam int FOPABS    = 6;
  localparam int FOPNEG    = 7;
  localparam int FOPCEQ    = 8;
  localparam int FOPCLT    = 9;
  localparam int FOPCLE    = 10;
  localparam int FOPSGNJ   = 11;
  localparam int FOPSGNJN  = 12;
  localparam int FOPSGNJX  = 13;
  localparam int FOPMIN    = 14;
  localparam int FOPMAX    = 15;
  localparam int FOPMOV    = 16;
  localparam int FOPCVTSW  = 17;
  localparam int FOPCVTSWU = 18;
  localparam int FOPCVTWS  = 19;
  localparam int FOPCVTWUS = 20;

  localparam int FLAG_NAN  = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_UNF  = 0;

  typedef struct packed {
    logic nan;
    logic zero;
    logic ovf;
    logic unf;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fpalu_lat_lut.sv
// Opcode -> cycle-count lookup for the FP sequencer.
// Combinational, zero latency; no flow control. Unlisted opcodes take LAT_SIMPLE.
module fpalu_lat_lut
  import fpalu_pkg::*;
#(
  parameter int CTRL_W     = 5,
  parameter int CNT_W      = 5,
  parameter int LAT_ADDSUB = 8,
  parameter int LAT_MUL    = 6,
  parameter int LAT_DIV    = 7,
  parameter int LAT_SQRT   = 17,
  parameter int LAT_CVT    = 7,
  parameter int LAT_SIMPLE = 1
) (
  input  logic [CTRL_W-1:0] control,
  output logic [CNT_W-1:0]  lat
);

  always_comb begin
    lat = CNT_W'(LAT_SIMPLE);
    case (int'(control))
      FOPADD, FOPSUB:                          lat = CNT_W'(LAT_ADDSUB);
      FOPMUL:                                  lat = CNT_W'(LAT_MUL);
      FOPDIV:                                  lat = CNT_W'(LAT_DIV);
      FOPSQRT:                                 lat = CNT_W'(LAT_SQRT);
      FOPCVTSW, FOPCVTSWU, FOPCVTWS, FOPCVTWUS: lat = CNT_W'(LAT_CVT);
      default:                                 lat = CNT_W'(LAT_SIMPLE);
    endcase
  end

endmodule

// File: rtl/fpalu_seq.sv
// Multicycle sequencer between FP execute and FP units; optional sticky flags via FPALU_STICKY_FLAGS_EN.
// Latency: response valid exactly LAT(op) cycles after the accepting edge.
// Backpressure: one op in flight; req_ready only when idle, result held until resp_ready.
module fpalu_seq
  import fpalu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int CTRL_W     = 5,
  parameter int CNT_W      = 5,
  parameter int LAT_ADDSUB = 8,
  parameter int LAT_MUL    = 6,
  parameter int LAT_DIV    = 7,
  parameter int LAT_SQRT   = 17,
  parameter int LAT_CVT    = 7,
  parameter int LAT_SIMPLE = 1
) (
  input  logic              iclock,
  input  logic              ireset_n,
  input  logic              ireq_valid,
  output logic              oreq_ready,
  input  logic [CTRL_W-1:0] icontrol,
  input  logic [WIDTH-1:0]  idataa,
  input  logic [WIDTH-1:0]  idatab,
  output logic [CTRL_W-1:0] ounit_control,
  output logic [WIDTH-1:0]  ounit_dataa,
  output logic [WIDTH-1:0]  ounit_datab,
  input  logic [WIDTH-1:0]  iunit_result,
  input  logic [3:0]        iunit_flags,
  output logic              oresp_valid,
  input  logic              iresp_ready,
  output logic [WIDTH-1:0]  oresult,
  output logic [3:0]        oflags,
  input  logic              iflags_clr,
  output logic [3:0]        osticky_flags
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Every latency must be nonzero and fit the down-counter.
  if (LAT_ADDSUB < 1 || LAT_ADDSUB > CNT_MAX || LAT_MUL  < 1 || LAT_MUL  > CNT_MAX ||
      LAT_DIV    < 1 || LAT_DIV    > CNT_MAX || LAT_SQRT < 1 || LAT_SQRT > CNT_MAX ||
      LAT_CVT    < 1 || LAT_CVT    > CNT_MAX || LAT_SIMPLE < 1 || LAT_SIMPLE > CNT_MAX) begin : g_lat_check
    $error("fpalu_seq: every LAT_* must be >= 1 and < 2**CNT_W");
  end

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  op_lat;
  logic              accept;
  logic              capture;
  flags_t            flags_q;

  fpalu_lat_lut #(
    .CTRL_W     (CTRL_W),
    .CNT_W      (CNT_W),
    .LAT_ADDSUB (LAT_ADDSUB),
    .LAT_MUL    (LAT_MUL),
    .LAT_DIV    (LAT_DIV),
    .LAT_SQRT   (LAT_SQRT),
    .LAT_CVT    (LAT_CVT),
    .LAT_SIMPLE (LAT_SIMPLE)
  ) u_lat_lut (
    .control (icontrol),
    .lat     (op_lat)
  );

  assign accept  = (state == ST_IDLE) && ireq_valid;
  assign capture = (state == ST_RUN) && (cnt == CNT_W'(1));
  assign oflags  = flags_q;

  always_comb begin
    state_nxt   = state;
    oreq_ready  = 1'b0;
    oresp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        oreq_ready = 1'b1;
        if (ireq_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        oresp_valid = 1'b1;
        if (iresp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  // Operands stay on the unit ports until the next accept, not just while running.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      cnt           <= '0;
      ounit_control <= '0;
      ounit_dataa   <= '0;
      ounit_datab   <= '0;
      oresult       <= '0;
      flags_q       <= '0;
    end else begin
      if (accept) begin
        cnt           <= op_lat;
        ounit_control <= icontrol;
        ounit_dataa   <= idataa;
        ounit_datab   <= idatab;
      end else if (state == ST_RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture) begin
        oresult <= iunit_result;
        flags_q <= iunit_flags;
      end
    end
  end

`ifdef FPALU_STICKY_FLAGS_EN
  logic       resp_hs;
  logic [3:0] sticky_q;

  assign resp_hs       = (state == ST_DONE) && iresp_ready;
  assign osticky_flags = sticky_q;

  // A clear landing on a handshake keeps only that response's flags.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n)       sticky_q <= '0;
    else if (resp_hs)    sticky_q <= (iflags_clr ? 4'b0 : sticky_q) | flags_q;
    else if (iflags_clr) sticky_q <= '0;
  end
`else
  logic unused_flags_clr;
  assign unused_flags_clr = iflags_clr;
  assign osticky_flags    = '0;
`endif

endmodule

// File: tb/tb_fpalu_seq.sv
// Scoreboard bench for fpalu_seq: random ops against a latency table and a time-varying unit model.
module tb_fpalu_seq;
  import fpalu_pkg::*;

  logic        iclock = 1'b0;
  logic        ireset_n;
  logic        ireq_valid;
  logic        oreq_ready;
  logic [4:0]  icontrol;
  logic [31:0] idataa, idatab;
  logic [4:0]  ounit_control;
  logic [31:0] ounit_dataa, ounit_datab;
  logic [31:0] iunit_result;
  logic [3:0]  iunit_flags;
  logic        oresp_valid;
  logic        iresp_ready;
  logic [31:0] oresult;
  logic [3:0]  oflags;
  logic        iflags_clr;
  logic [3:0]  osticky_flags;

  fpalu_seq dut (
    .iclock        (iclock),
    .ireset_n      (ireset_n),
    .ireq_valid    (ireq_valid),
    .oreq_ready    (oreq_ready),
    .icontrol      (icontrol),
    .idataa        (idataa),
    .idatab        (idatab),
    .ounit_control (ounit_control),
    .ounit_dataa   (ounit_dataa),
    .ounit_datab   (ounit_datab),
    .iunit_result  (iunit_result),
    .iunit_flags   (iunit_flags),
    .oresp_valid   (oresp_valid),
    .iresp_ready   (iresp_ready),
    .oresult       (oresult),
    .oflags        (oflags),
    .iflags_clr    (iflags_clr),
    .osticky_flags (osticky_flags)
  );

  always #5 iclock = ~iclock;

  int cyc = 0;
  always @(posedge iclock) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          acc;
    int          lat;
  } txn_t;

  txn_t       q[$];
  int         lat_tbl[32];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         seen = 1'b0;
  bit         hold_rdy = 1'b0;
  bit         rand_rdy = 1'b0;
  bit         clr_en = 1'b0;
  bit         gaps = 1'b0;
  logic [3:0] sticky_m = 4'b0;

  // Unit stand-in: output depends on held operands and on the current cycle, so a
  // capture on the wrong edge or from wrong operands shows up in the result.
  function automatic logic [31:0] unit_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return a ^ {b[15:0], b[31:16]} ^ {27'd0, op};
  endfunction

  function automatic logic [3:0] flag_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    return a[3:0] ^ b[7:4] ^ op[3:0];
  endfunction

  assign iunit_result = unit_fn(ounit_control, ounit_dataa, ounit_datab) ^ 32'(cyc);
  assign iunit_flags  = flag_fn(ounit_control, ounit_dataa, ounit_datab) ^ 4'(cyc);

  function automatic logic [31:0] exp_res(input txn_t t);
    return unit_fn(t.op, t.a, t.b) ^ 32'(t.acc + t.lat);
  endfunction

  function automatic logic [3:0] exp_flg(input txn_t t);
    return flag_fn(t.op, t.a, t.b) ^ 4'(t.acc + t.lat);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge iclock) begin
    #1;
    iresp_ready = hold_rdy ? 1'b0 : (rand_rdy ? ($urandom_range(3, 0) != 0) : 1'b1);
    iflags_clr  = clr_en && ($urandom_range(7, 0) == 0);
  end

  // Monitor: compares response against the head of the scoreboard queue.
  always @(negedge iclock) begin
    if (ireset_n) begin
      chk("req_ready", 32'(oreq_ready), 32'(q.size() == 0));
      chk("sticky", 32'(osticky_flags), 32'(sticky_m));
      if (oresp_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_resp: got result %h with no request outstanding (cycle %0d)", oresult, cyc);
        end else begin
          if (!seen) begin
            chk("latency", 32'(cyc - q[0].acc - 1), 32'(q[0].lat));
            chk("result", oresult, exp_res(q[0]));
            chk("flags", 32'(oflags), 32'(exp_flg(q[0])));
            seen = 1'b1;
          end
          if (iresp_ready) begin
            chk("held_result", oresult, exp_res(q[0]));
`ifdef FPALU_STICKY_FLAGS_EN
            sticky_m = (iflags_clr ? 4'b0 : sticky_m) | exp_flg(q[0]);
`endif
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end else begin
        seen = 1'b0;
`ifdef FPALU_STICKY_FLAGS_EN
        if (iflags_clr) sticky_m = 4'b0;
`endif
      end
    end
  end

  // One cycle of driver activity: junk requests while busy must be ignored.
  task automatic tick();
    @(posedge iclock);
    #1;
    if (oreq_ready) begin
      ireq_valid = 1'b0;
    end else begin
      ireq_valid = 1'($urandom);
      icontrol   = 5'($urandom);
      idataa     = $urandom;
      idatab     = $urandom;
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    txn_t t;
    int   k = 0;
    bit   sent = 1'b0;
    while (!sent) begin
      @(posedge iclock);
      #1;
      if (oreq_ready && (!gaps || $urandom_range(2, 0) != 0)) begin
        icontrol   = op;
        idataa     = a;
        idatab     = b;
        ireq_valid = 1'b1;
        t.op  = op;
        t.a   = a;
        t.b   = b;
        t.acc = cyc;
        t.lat = lat_tbl[op];
        @(posedge iclock);
        #1;
        q.push_back(t);
        ireq_valid = 1'b0;
        sent = 1'b1;
      end else begin
        if (oreq_ready) ireq_valid = 1'b0;
        else begin
          ireq_valid = 1'($urandom);
          icontrol   = 5'($urandom);
          idataa     = $urandom;
          idatab     = $urandom;
        end
        k++;
        if (k > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL issue_timeout: oreq_ready stayed %b for 200 cycles, required 1", oreq_ready);
          sent = 1'b1;
        end
      end
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || oresp_valid) && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", q.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int   k;
    foreach (lat_tbl[i]) lat_tbl[i] = 1;
    lat_tbl[FOPADD]  = 8;  lat_tbl[FOPSUB]    = 8;
    lat_tbl[FOPMUL]  = 6;  lat_tbl[FOPDIV]    = 7;
    lat_tbl[FOPSQRT] = 17;
    lat_tbl[FOPCVTSW] = 7; lat_tbl[FOPCVTSWU] = 7;
    lat_tbl[FOPCVTWS] = 7; lat_tbl[FOPCVTWUS] = 7;

    ireset_n   = 1'b0;
    ireq_valid = 1'b0;
    icontrol   = '0;
    idataa     = '0;
    idatab     = '0;
    iresp_ready = 1'b0;
    iflags_clr  = 1'b0;
    repeat (2) @(posedge iclock);
    #1;
    chk("rst_req_ready", 32'(oreq_ready), 32'd1);
    chk("rst_resp_valid", 32'(oresp_valid), 32'd0);
    chk("rst_result", oresult, 32'd0);
    chk("rst_flags", 32'(oflags), 32'd0);
    chk("rst_sticky", 32'(osticky_flags), 32'd0);
    chk("rst_unit_ctl", 32'(ounit_control), 32'd0);
    chk("rst_unit_a", ounit_dataa, 32'd0);
    chk("rst_unit_b", ounit_datab, 32'd0);
    #2 ireset_n = 1'b1;

    issue(5'(FOPADD), 32'h3F800000, 32'h40000000);
    chk("add_unit_a", ounit_dataa, 32'h3F800000);
    chk("add_unit_b", ounit_datab, 32'h40000000);
    drain();
    issue(5'(FOPSQRT), $urandom, $urandom);
    issue(5'(FOPNEG), $urandom, $urandom);
    drain();

    // Hold the response for a while; it must stay put and junk requests must be dropped.
    hold_rdy = 1'b1;
    issue(5'(FOPMUL), $urandom, $urandom);
    t = q[0];
    k = 0;
    while (!oresp_valid && k < 50) begin
      tick();
      k++;
    end
    repeat (5) begin
      tick();
      chk("stall_valid", 32'(oresp_valid), 32'd1);
      chk("stall_result", oresult, exp_res(t));
      chk("stall_flags", 32'(oflags), 32'(exp_flg(t)));
    end
    hold_rdy = 1'b0;
    drain();

    // Reset in the middle of a divide: op dropped, nothing comes back.
    issue(5'(FOPDIV), $urandom, $urandom);
    tick();
    tick();
    ireq_valid = 1'b0;
    ireset_n   = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(oreq_ready), 32'd1);
    chk("midrst_resp_valid", 32'(oresp_valid), 32'd0);
    chk("midrst_result", oresult, 32'd0);
    chk("midrst_unit_ctl", 32'(ounit_control), 32'd0);
    chk("midrst_unit_a", ounit_dataa, 32'd0);
    chk("midrst_sticky", 32'(osticky_flags), 32'd0);
    q.delete();
    seen     = 1'b0;
    sticky_m = 4'b0;
    #1 ireset_n = 1'b1;
    repeat (20) tick();
    chk("midrst_no_resp", 32'(oresp_valid), 32'd0);

    rand_rdy = 1'b1;
    clr_en   = 1'b1;
    gaps     = 1'b1;
    for (int i = 0; i < 200; i++) begin
      issue(5'($urandom), $urandom, $urandom);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
